// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers for the MIPS EX stage. Supports signed/unsigned
//               multiply (shift-add), signed/unsigned divide (restoring
//               shift-subtract) and direct HI/LO writes (mthi/mtlo).
//               Operations take WIDTH iterations on operand magnitudes,
//               followed by one sign-fixup cycle that writes HI/LO.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   launch an operation (sampled only when idle)
//   op_div   in   0 = multiply, 1 = divide
//   op_sign  in   1 = signed operands, 0 = unsigned
//   a        in   multiplicand / dividend (rs), also the mthi/mtlo data
//   b        in   multiplier / divisor (rt)
//   mthi     in   write a into hi (idle only)
//   mtlo     in   write a into lo (idle only)
//   busy     out  operation in progress
//   done     out  one-cycle pulse when hi/lo receive a result
//   hi       out  HI register (product high half / remainder)
//   lo       out  LO register (product low half / quotient)
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [2*WIDTH-1:0] acc_q,      acc_d;
    logic [WIDTH-1:0]   mag_b_q,    mag_b_d;
    logic [WIDTH-1:0]   a_raw_q,    a_raw_d;
    logic [WIDTH-1:0]   hi_q,       hi_d;
    logic [WIDTH-1:0]   lo_q,       lo_d;
    logic               sign_a_q,   sign_a_d;
    logic               sign_b_q,   sign_b_d;
    logic               op_div_q,   op_div_d;
    logic               op_sign_q,  op_sign_d;
    logic               div_zero_q, div_zero_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    // ------------------------------------------------------------------
    // Operand magnitudes at launch
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    always_comb begin
        mag_a_in = (op_sign && a[WIDTH-1]) ? -a : a;
        mag_b_in = (op_sign && b[WIDTH-1]) ? -b : b;
    end

    // ------------------------------------------------------------------
    // One multiply iteration: the accumulator holds {partial, multiplier}.
    // The LSB of the remaining multiplier decides whether |b| is added to
    // the upper half; the carry is kept by shifting the W+1 bit sum back in.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // One restoring-divide iteration: the accumulator holds
    // {remainder, dividend/quotient}. The remainder is shifted left with
    // the next dividend bit; the trial value is one bit wider so the
    // compare against the divisor never loses the shifted-out MSB.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_trial >= {1'b0, mag_b_q});
        div_rem   = div_ge ? (div_trial[WIDTH-1:0] - mag_b_q) : div_trial[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end

    // ------------------------------------------------------------------
    // Sign fixup applied in the final cycle
    // ------------------------------------------------------------------
    logic               neg_result;
    logic               neg_rem;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    always_comb begin
        neg_result = op_sign_q && (sign_a_q ^ sign_b_q);
        // Remainder follows the dividend's sign
        neg_rem    = op_sign_q && sign_a_q;
        prod_fixed = neg_result ? -acc_q : acc_q;
        quot_fixed = neg_result ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fixed  = neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_b_d    = mag_b_q;
        a_raw_d    = a_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        op_div_d   = op_div_q;
        op_sign_d  = op_sign_q;
        div_zero_d = div_zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Direct writes land even when start launches in the same
                // cycle; the operation's result overwrites them later.
                if (mthi) begin
                    hi_d = a;
                end
                if (mtlo) begin
                    lo_d = a;
                end
                if (start) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    acc_d      = {{WIDTH{1'b0}}, mag_a_in};
                    mag_b_d    = mag_b_in;
                    a_raw_d    = a;
                    sign_a_d   = a[WIDTH-1];
                    sign_b_d   = b[WIDTH-1];
                    op_div_d   = op_div;
                    op_sign_d  = op_sign;
                    div_zero_d = (b == '0);
                    busy_d     = 1'b1;
                end
            end

            S_RUN: begin
                acc_d = op_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (!op_div_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else if (div_zero_q) begin
                    // Divide by zero returns the raw dividend and all ones
                    hi_d = a_raw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_b_q    <= '0;
            a_raw_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            op_div_q   <= 1'b0;
            op_sign_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_b_q    <= mag_b_d;
            a_raw_q    <= a_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            op_div_q   <= op_div_d;
            op_sign_q  <= op_sign_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        op_sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    mul_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_div  (op_div),
        .op_sign (op_sign),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and observe it for 40 cycles. Operands are
    // scrambled after launch so the result must come from latched values.
    // done_edge is the index of the edge (start edge = 0) that produced done.
    task automatic run_op(input logic d, input logic s,
                          input logic [31:0] ia, input logic [31:0] ib,
                          output int busy_cnt, output int done_cnt,
                          output int done_edge);
        @(negedge clk);
        op_div = d; op_sign = s; a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 32'h5A5A_0F0F; b = 32'h0000_0000;
        op_div = ~d; op_sign = ~s;
        busy_cnt = 0; done_cnt = 0; done_edge = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k - 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got %b expected 0", done);
        end
        vectors++;
        if ({hi, lo} !== 64'h0) begin
            miscompares++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult_signed();
        int bc, dc, de;
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            miscompares++; $display("FAIL mult_m3x5: got %h expected ffffffff_fffffff1", {hi, lo});
        end
        vectors++;
        if (bc !== 33) begin
            miscompares++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc);
        end
        vectors++;
        if (de !== 33) begin
            miscompares++; $display("FAIL mult_done_edge: got %0d expected 33", de);
        end
        vectors++;
        if (dc !== 1) begin
            miscompares++; $display("FAIL mult_done_width: got %0d expected 1", dc);
        end
    endtask

    task automatic test_mult_max();
        int bc, dc, de;
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++; $display("FAIL multu_max: got %h expected fffffffe_00000001", {hi, lo});
        end
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'h0000_0000_0000_0001) begin
            miscompares++; $display("FAIL mult_m1xm1: got %h expected 00000000_00000001", {hi, lo});
        end
        run_op(1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_0000, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFF_0000_0000) begin
            miscompares++; $display("FAIL mult_pos_neg: got %h expected ffffffff_00000000", {hi, lo});
        end
    endtask

    task automatic test_div();
        int bc, dc, de;
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            miscompares++; $display("FAIL div_m7_2: got %h expected ffffffff_fffffffd", {hi, lo});
        end
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'h0000_0001_7FFF_FFFC) begin
            miscompares++; $display("FAIL divu_big_2: got %h expected 00000001_7ffffffc", {hi, lo});
        end
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            miscompares++; $display("FAIL div_overflow: got %h expected 00000000_80000000", {hi, lo});
        end
        // 100 / -7 = -14 rem 2 (remainder keeps the dividend's sign)
        run_op(1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'h0000_0002_FFFF_FFF2) begin
            miscompares++; $display("FAIL div_100_m7: got %h expected 00000002_fffffff2", {hi, lo});
        end
        vectors++;
        if (de !== 33) begin
            miscompares++; $display("FAIL div_done_edge: got %0d expected 33", de);
        end
    endtask

    task automatic test_div_zero();
        int bc, dc, de;
        run_op(1'b1, 1'b0, 32'd7, 32'd0, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin
            miscompares++; $display("FAIL divu_by_zero: got %h expected 00000007_ffffffff", {hi, lo});
        end
        vectors++;
        if (bc !== 33) begin
            miscompares++; $display("FAIL divz_busy_cycles: got %0d expected 33", bc);
        end
        vectors++;
        if (dc !== 1) begin
            miscompares++; $display("FAIL divz_done_width: got %0d expected 1", dc);
        end
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFF9_FFFF_FFFF) begin
            miscompares++; $display("FAIL div_signed_by_zero: got %h expected fffffff9_ffffffff", {hi, lo});
        end
    endtask

    task automatic test_busy_ignore();
        int de;
        @(negedge clk);
        op_div = 1'b0; op_sign = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'h0000_AAAA; b = 32'd9; op_div = 1'b1; start = 1'b1; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        de = -1;
        for (int k = 11; k <= 45; k++) begin
            if (done && de < 0) de = k;
            if (k < 45) @(negedge clk);
        end
        vectors++;
        if ({hi, lo} !== 64'h0000_0000_0000_000C) begin
            miscompares++; $display("FAIL busy_ignore_result: got %h expected 00000000_0000000c", {hi, lo});
        end
        vectors++;
        if (de !== 34) begin
            miscompares++; $display("FAIL busy_ignore_latency: got done at sample %0d expected 34", de);
        end
        @(negedge clk);
        a = 32'h0000_1234; mtlo = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        vectors++;
        if ({hi, lo} !== 64'h0000_0000_0000_1234) begin
            miscompares++; $display("FAIL mtlo_idle: got %h expected 00000000_00001234", {hi, lo});
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL mtlo_no_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_async_reset();
        int bc, dc, de;
        @(negedge clk);
        op_div = 1'b0; op_sign = 1'b1; a = 32'h0000_0100; b = 32'h0000_0200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_done: got %b expected 0", done);
        end
        vectors++;
        if ({hi, lo} !== 64'h0) begin
            miscompares++; $display("FAIL async_reset_hilo: got %h expected 0", {hi, lo});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if ({done, hi, lo} !== 65'h0) begin
            miscompares++; $display("FAIL reset_discards_op: got %h expected 0", {done, hi, lo});
        end
        run_op(1'b0, 1'b0, 32'd2, 32'd3, bc, dc, de);
        vectors++;
        if ({hi, lo} !== 64'h0000_0000_0000_0006) begin
            miscompares++; $display("FAIL post_reset_multu: got %h expected 00000000_00000006", {hi, lo});
        end
        vectors++;
        if (de !== 33) begin
            miscompares++; $display("FAIL post_reset_latency: got %0d expected 33", de);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op_div  = 1'b0;
        op_sign = 1'b0;
        a       = '0;
        b       = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;

        test_reset();
        test_mult_signed();
        test_mult_max();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It replaces the single-mode start_mult/mult_sign multiplier with a parametrised engine that supports:
- signed and unsigned multiply
- signed and unsigned divide
- direct HI/LO writes (mthi/mtlo)

It sits beside the ALU in EX. The controller holds the pipeline while busy is high, and mfhi/mflo read hi/lo.

Parameters:
WIDTH, 32, operand width; product and {remainder, quotient} are 2*WIDTH bits, split into hi/lo.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch an operation; sampled only in IDLE
op_div  input  1  0 = multiply, 1 = divide
op_sign  input  1  1 = signed operands (mult/div), 0 = unsigned (multu/divu)
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
mthi  input  1  write a into hi
mtlo  input  1  write a into lo
busy  output  1  operation in progress; controller must stall mfhi/mflo/start
done  output  1  one-cycle pulse when hi/lo receive a result
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset, asynchronous at any time including mid-operation:
  - state = IDLE
  - hi = 0, lo = 0, busy = 0, done = 0
  - internal accumulators and counter cleared
  - the in-flight result is discarded
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN on a clk edge with start = 1:
  - latch magnitudes |a| and |b| (two's-complement negate when op_sign = 1 and the MSB is set)
  - latch sign_a, sign_b, op_div, op_sign; clear counter
  - busy = 1 from the next cycle
- RUN, one iteration per edge, exactly WIDTH edges; the counter increments and RUN -> FIX when counter == WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator, unsigned on magnitudes.
  - Divide: restoring shift-subtract producing an unsigned quotient and remainder of magnitudes.
- FIX, one edge: apply signs, write hi/lo, done = 1 for that one cycle, busy = 0, state = IDLE.
  - Signed multiply: negate the 2*WIDTH product if sign_a ^ sign_b.
  - Signed divide: quotient negated if sign_a ^ sign_b; remainder takes the sign of the dividend (sign_a).
- Latency:
  - start sampled at edge E0; hi/lo updated at edge E(WIDTH+1).
  - busy is high for exactly WIDTH+1 cycles; done is high during the cycle following E(WIDTH+1).
- Divide by zero (b == 0), independent of op_sign: hi = a as originally presented, lo = all ones. Latency is unchanged.
- Overflow case: signed -2^(WIDTH-1) / -1 gives lo = 0x8000_0000, hi = 0 (natural wrap, no trap).
- Multiply results are never truncated: the full 2*WIDTH product goes to {hi, lo}.
- start while busy is ignored; no queueing, and the running operation is unaffected.
- mthi/mtlo:
  - In IDLE, applied at the clk edge.
  - If asserted together with start, the write is applied and the operation still launches; its result overwrites hi/lo at FIX.
  - While busy = 1, ignored.
- hi/lo hold their values between results; an unsigned operation does not depend on sign state.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- mult (op_div=0, op_sign=1), a=0xFFFFFFFD (-3), b=5, WIDTH=32 -> busy high 33 cycles, done at edge 33 after start, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with mult -> hi=0, lo=1.
- div signed, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu on the same operands -> lo=0x7FFFFFFC, hi=1; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=7, b=0 -> hi=7, lo=0xFFFFFFFF after 33 cycles; done pulses exactly one cycle.
- Launch multu 3*4, then at cycle 10 pulse start with different operands and pulse mthi with a=0xAAAA -> both ignored; result hi=0, lo=12. Then in IDLE, mtlo with a=0x1234 -> lo=0x1234 next cycle.
- Start mult, assert reset asynchronously at cycle 15 (mid-clock) -> busy, done, hi, lo go to 0 immediately without a clock edge. After release, start multu 2*3 -> lo=6 at normal latency.
